// File: rtl/encoder_8to3_queued_pkg.sv
// Shared types and constants for the queued 8-to-3 priority encoder.
// Holds the delivery FSM states and the request/code widths.
package encoder_8to3_queued_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned CODE_W  = 3;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

    // Expands a code back into the single pending bit it refers to.
    function automatic logic [NUM_REQ-1:0] code_to_mask(input logic [CODE_W-1:0] code);
        logic [NUM_REQ-1:0] mask;
        mask = '0;
        mask[code] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/encoder_8to3_queued_prio_enc8.sv
// Combinational 8-input priority encoder; bit 7 has the highest priority.
// Produces the index of the highest set bit and a flag that any bit is set.
module prio_enc8
    import encoder_8to3_queued_pkg::*;
(
    input  logic [NUM_REQ-1:0] p,
    output logic [CODE_W-1:0]  idx,
    output logic               any
);

    always_comb begin
        idx = '0;
        any = |p;
        // Ascending scan so the highest set bit is the last one written.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (p[k]) begin
                idx = CODE_W'(k);
            end
        end
    end

endmodule

// File: rtl/encoder_8to3_queued.sv
// Queued 8-to-3 encoder: active-low requests are latched into a pending register
// and delivered highest-first, one registered code per accepted cycle.
module encoder_8to3_queued
    import encoder_8to3_queued_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic Y7,
    input  logic Y6,
    input  logic Y5,
    input  logic Y4,
    input  logic Y3,
    input  logic Y2,
    input  logic Y1,
    input  logic Y0,
    input  logic ready,
    output logic A,
    output logic B,
    output logic C,
    output logic valid,
    output logic pend_any,
    output logic ovf
);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  pend_q, pend_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                ovf_q, ovf_d;

    logic [NUM_REQ-1:0]  req_low;
    logic [NUM_REQ-1:0]  cap_mask;
    logic [NUM_REQ-1:0]  clr_mask;
    logic [CODE_W-1:0]   sel_idx;
    logic                sel_any;
    logic                take;

    assign req_low  = ~{Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
    assign cap_mask = en ? req_low : '0;

    // Selection only ever sees the registered pending bits.
    prio_enc8 u_prio_enc8 (
        .p   (pend_q),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel_any) begin
                    take    = 1'b1;
                    code_d  = sel_idx;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (ready) begin
                    if (sel_any) begin
                        take   = 1'b1;
                        code_d = sel_idx;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        clr_mask = take ? code_to_mask(sel_idx) : '0;
        // A fresh capture on a bit being cleared re-pends it rather than losing it.
        pend_d   = (pend_q & ~clr_mask) | cap_mask;
        ovf_d    = ovf_q | (|(cap_mask & pend_q & ~clr_mask));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pend_q  <= '0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign {A, B, C} = code_q;
    assign valid     = (state_q == StHold);
    assign pend_any  = |pend_q;
    assign ovf       = ovf_q;

endmodule
